// File: rtl/crc32_stream_if.sv
// Stream-in / result-out bundle for crc32_stream.
// The master modport is the side that supplies beats and accepts results.
interface crc32_stream_if #(
    parameter int DATA_W = 32
);
    localparam int KEEP_W = DATA_W / 8;

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [KEEP_W-1:0] s_keep;
    logic              s_last;
    logic              s_abort;
    logic              m_valid;
    logic              m_ready;
    logic [31:0]       m_crc;
    logic              m_ok;
    logic              busy;

    modport master (
        output s_valid, s_data, s_keep, s_last, s_abort, m_ready,
        input  s_ready, m_valid, m_crc, m_ok, busy
    );

    modport slave (
        input  s_valid, s_data, s_keep, s_last, s_abort, m_ready,
        output s_ready, m_valid, m_crc, m_ok, busy
    );
endinterface

// File: rtl/crc32_stream.sv
// Streaming reflected CRC-32 (0xEDB88320) over DATA_W-bit beats with partial last beat,
// abort, and a single-entry registered result carrying the FCS and residue check.

// One byte of the reflected CRC update; a disabled lane passes the register through.
module crc32_lane (
    input  logic        en,
    input  logic [7:0]  data,
    input  logic [31:0] crc_in,
    output logic [31:0] crc_out
);
    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        crc_out = en ? c : crc_in;
    end
endmodule

module crc32_stream #(
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    crc32_stream_if.slave bus
);
    localparam int          KEEP_W   = DATA_W / 8;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] RESIDUE  = 32'hDEBB20E3;

    logic                   accept;
    logic                   frame_end;
    logic [31:0]            crc;
    logic [31:0]            next_crc;
    logic [KEEP_W-1:0]      lane_en;
    logic [KEEP_W:0][31:0]  chain;
    logic                   busy_q;
    logic                   m_valid_q;
    logic [31:0]            m_crc_q;
    logic                   m_ok_q;

    assign bus.s_ready = ~m_valid_q | bus.m_ready;
    assign accept      = bus.s_valid & bus.s_ready;
    assign frame_end   = bus.s_last | bus.s_abort;

    // Lane enables are a running AND of keep from lane 0, so the first zero
    // truncates the beat; keep only matters on the last beat.
    always_comb begin
        logic run;
        run     = 1'b1;
        lane_en = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            run        = run & (bus.s_keep[i] | ~bus.s_last);
            lane_en[i] = run;
        end
    end

    assign chain[0] = crc;

    for (genvar i = 0; i < KEEP_W; i++) begin : g_lane
        crc32_lane u_lane (
            .en      (lane_en[i]),
            .data    (bus.s_data[8*i +: 8]),
            .crc_in  (chain[i]),
            .crc_out (chain[i+1])
        );
    end

    assign next_crc = chain[KEEP_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            crc       <= CRC_INIT;
            busy_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_crc_q   <= 32'h0;
            m_ok_q    <= 1'b0;
        end else begin
            // Reload on frame end so the next frame may start on the very next beat.
            if (accept) begin
                crc    <= frame_end ? CRC_INIT : next_crc;
                busy_q <= ~frame_end;
            end
            if (accept && bus.s_last && !bus.s_abort) begin
                m_valid_q <= 1'b1;
                m_crc_q   <= ~next_crc;
                m_ok_q    <= (next_crc == RESIDUE);
            end else if (bus.m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_crc   = m_crc_q;
    assign bus.m_ok    = m_ok_q;
    assign bus.busy    = busy_q;
endmodule
